fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have input CLOCK_50, 1 bit, the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit, a synchronous, active-high reset sampled on CLOCK_50.
REQ-003 The block SHALL have output mem_addr, 12 bits, the instruction ROM word address (current fetch PC).
REQ-004 The block SHALL have output mem_req, 1 bit; high means mem_addr is a valid read this cycle.
REQ-005 The block SHALL have input mem_q, 16 bits, the ROM data, valid exactly 1 cycle after the matching mem_req.
REQ-006 The block SHALL have output instr_out, 16 bits, the instruction at the queue head.
REQ-007 The block SHALL have output instr_pc, 12 bits, the address of instr_out.
REQ-008 The block SHALL have output instr_valid, 1 bit; high means the queue holds at least one entry.
REQ-009 The block SHALL have input instr_ready, 1 bit; when high together with instr_valid, the consumer takes the head this cycle.
REQ-010 The block SHALL have input redirect, 1 bit, a branch/jump taken by the execute stage.
REQ-011 The block SHALL have input redirect_pc, 12 bits, the new fetch target, valid with redirect.

Function
REQ-012 The block SHALL hold a 4-entry FIFO of {pc[11:0], instr[15:0]} with a 3-bit occupancy count and 2-bit wrapping read/write pointers.
REQ-013 The block SHALL have FSM states: BOOT, FETCH, FLUSH.
- BOOT: entered on reset; leaves to FETCH on the first cycle with reset low.
- FETCH: normal issue; goes to FLUSH on redirect.
- FLUSH: lasts one cycle; returns to FETCH.
REQ-014 The block SHALL assert mem_req in FETCH only when occupancy + in-flight < 4 and redirect is low; in-flight is a 1-bit register equal to the previous cycle's mem_req.
REQ-015 On an issued request, the block SHALL increment fetch_pc by 1 modulo 4096 (12'hFFF wraps to 12'h000).
REQ-016 When in-flight is set, the block SHALL write mem_q, tagged with the issuing PC, into the FIFO.
REQ-017 A pop (instr_valid && instr_ready) and a push in the same cycle SHALL leave occupancy unchanged.
REQ-018 When the FIFO is empty, the block SHALL drive instr_valid=0, instr_out=16'h0000 and instr_pc=12'h000.
REQ-019 On redirect, the block SHALL:
- load fetch_pc with redirect_pc;
- clear the FIFO;
- drop any in-flight response;
- ignore a simultaneous pop;
- force mem_req low that cycle.
REQ-020 Redirect latency SHALL be: redirect at cycle T, mem_addr=redirect_pc with mem_req at T+1, instr_valid with instr_pc=redirect_pc at T+3 (no bypass).
REQ-021 A redirect during FLUSH SHALL restart FLUSH with the newest redirect_pc.
REQ-022 With back-to-back ready and no redirect, the block SHALL sustain one instruction per cycle.

Reset
REQ-023 While reset is high, the block SHALL drive:
- fetch_pc=0, occupancy=0, pointers=0, in-flight=0;
- mem_req=0, instr_valid=0, instr_out=0, instr_pc=0;
- state=BOOT.
REQ-024 Reset asserted mid-operation SHALL override redirect and discard all queued and in-flight data.
REQ-025 In the first cycle after reset falls, the block SHALL issue address 0.

Configuration
REQ-026 With macro FETCH_EARLY_JUMP_EN defined, when a pushed instruction has opcode instr[15:12]==OP_JUMP, the block SHALL:
- load fetch_pc with instr[11:0];
- cancel the request issued in that same cycle, which is never enqueued;
- still enqueue the jump itself.
REQ-027 Without FETCH_EARLY_JUMP_EN, the block SHALL treat jumps as ordinary instructions; control flow changes only via redirect.

Structure
REQ-028 A shared package SHALL define OP_JUMP=4'hF, FETCH_DEPTH=4, PC_W=12, INSTR_W=16 and the FSM state enum.
REQ-029 The FIFO SHALL be a sub-module fetch_queue (push/pop/flush, full/empty, occupancy); fetch_unit holds the FSM, PC and in-flight tracking.

Verification
REQ-030 Reset release with ROM[i]=16'h1000+i and ready=1 -> instr_valid first high 2 cycles later, then PCs 0,1,2,... consecutively, one per cycle.
REQ-031 ready=0 for 10 cycles -> exactly 4 entries queued, mem_req low; on ready=1 -> PCs 0..3 then 4, with no gap or duplicate.
REQ-032 redirect with redirect_pc=12'h0A0 while 3 entries are queued -> queue empty next cycle, mem_addr=0A0 at T+1, instr_pc=0A0 at T+3, old entries never seen.
REQ-033 fetch_pc=12'hFFE, free-running -> PCs FFE, FFF, 000, 001.
REQ-034 With FETCH_EARLY_JUMP_EN defined and ROM[5]=16'hF040 -> delivered PCs ...,4,5,040,041 with no redirect; without the macro -> ...,5,6,7.
REQ-035 reset pulse while 2 entries are queued and redirect is high -> all outputs 0, then restart from PC 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_unit_pkg;

  localparam logic [3:0] OP_JUMP     = 4'hF;
  localparam int         FETCH_DEPTH = 4;
  localparam int         PC_W        = 12;
  localparam int         INSTR_W     = 16;
  localparam int         CNT_W       = 3;
  localparam int         PTR_W       = 2;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4] == OP_JUMP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Four-entry instruction queue of {pc, instr} with flush; head reads as zero when empty.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  entry_t            mem [FETCH_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == CNT_W'(FETCH_DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible because head is gated by empty.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, ROM request issue, in-flight tracking and redirect flush.
// Optional build macro FETCH_EARLY_JUMP_EN follows jump opcodes as they are enqueued.
//
// state    | meaning
// ST_BOOT  | held in reset; no requests
// ST_FETCH | normal issue while queue credit allows
// ST_FLUSH | one cycle after a redirect; first request to the new target
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_req,
  input  logic [INSTR_W-1:0] mem_q,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  state_t            state;
  state_t            state_nx;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   inflight_pc;
  logic              in_flight;
  logic              push;
  logic              pop;
  logic              jump_push;
  logic              credit_ok;
  entry_t            push_data;
  entry_t            head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  occupancy;

  // Responses arriving in a redirect cycle belong to the abandoned path.
  assign push      = in_flight && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;
  assign push_data = '{pc: inflight_pc, instr: mem_q};
  assign credit_ok = !full && ((occupancy + CNT_W'(in_flight)) < CNT_W'(FETCH_DEPTH));

`ifdef FETCH_EARLY_JUMP_EN
  assign jump_push = push && is_jump(mem_q);
`else
  assign jump_push = 1'b0;
`endif

  fetch_queue u_queue (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_BOOT:  state_nx = ST_FETCH;
      ST_FETCH: if (redirect) state_nx = ST_FLUSH;
      ST_FLUSH: state_nx = redirect ? ST_FLUSH : ST_FETCH;
      default:  state_nx = ST_BOOT;
    endcase
  end

  // The flush cycle issues the redirect target so it is on the bus one cycle after redirect.
  always_comb begin
    mem_req = 1'b0;
    if (!reset && !redirect && credit_ok &&
        (state == ST_FETCH || state == ST_FLUSH))
      mem_req = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      in_flight   <= 1'b0;
    end else begin
      // A request issued alongside an enqueued jump is on the wrong path and is never kept.
      in_flight <= mem_req && !jump_push;
      if (mem_req) inflight_pc <= fetch_pc;
      if (redirect)       fetch_pc <= redirect_pc;
      else if (jump_push) fetch_pc <= mem_q[PC_W-1:0];
      else if (mem_req)   fetch_pc <= fetch_pc + PC_W'(1);
    end
  end

  assign mem_addr    = reset ? '0 : fetch_pc;
  assign instr_valid = !empty && !reset;
  assign instr_out   = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot stream, backpressure, redirect, wrap, flush restart, jumps, reset.
module tb_fetch_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic [15:0] mem_q = 16'h0000;
  logic [15:0] instr_out;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [4096];

  always #10 CLOCK_50 = ~CLOCK_50;

  fetch_unit dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_q       (mem_q),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // ROM answers one cycle after a request; unrequested cycles return junk.
  always @(posedge CLOCK_50) mem_q <= mem_req ? rom[mem_addr] : 16'hDEAD;

  task automatic do_reset(input logic rdy);
    @(negedge CLOCK_50);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 12'h000; instr_ready = rdy;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 12'h000) begin
      failures++; $display("FAIL reset_mem req=%b addr=%h expected req=0 addr=000", mem_req, mem_addr);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 12'h000) begin
      failures++; $display("FAIL reset_out valid=%b instr=%h pc=%h expected 0/0000/000", instr_valid, instr_out, instr_pc);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    reset = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL boot_idle req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLOCK_50); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 12'(j - 1)) begin
        failures++; $display("FAIL stream_issue cyc=%0d req=%b addr=%h expected 1/%h", j, mem_req, mem_addr, 12'(j - 1));
      end
      checks++;
      if (j < 3) begin
        if (instr_valid !== 1'b0) begin
          failures++; $display("FAIL stream_early cyc=%0d valid=%b expected 0", j, instr_valid);
        end
      end else if (instr_valid !== 1'b1 || instr_pc !== 12'(j - 3) || instr_out !== 16'(32'h1000 + j - 3)) begin
        failures++; $display("FAIL stream_deliver cyc=%0d valid=%b pc=%h instr=%h expected 1/%h/%h",
                             j, instr_valid, instr_pc, instr_out, 12'(j - 3), 16'(32'h1000 + j - 3));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    reset = 1'b0;
    for (int j = 1; j < 10; j++) @(negedge CLOCK_50);
    #1;
    checks++;
    if (mem_req !== 1'b0 || dut.u_queue.occupancy !== 3'd4) begin
      failures++; $display("FAIL bp_full req=%b occ=%0d expected 0/4", mem_req, dut.u_queue.occupancy);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 12'h000) begin
      failures++; $display("FAIL bp_head valid=%b pc=%h expected 1/000", instr_valid, instr_pc);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK_50); instr_ready = 1'b1; #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 12'(k) || instr_out !== 16'(32'h1000 + k)) begin
        failures++; $display("FAIL bp_drain k=%0d valid=%b pc=%h instr=%h expected 1/%h/%h",
                             k, instr_valid, instr_pc, instr_out, 12'(k), 16'(32'h1000 + k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    reset = 1'b0;
    for (int j = 1; j <= 5; j++) @(negedge CLOCK_50);
    #1;
    checks++;
    if (dut.u_queue.occupancy !== 3'd3 || instr_pc !== 12'h000) begin
      failures++; $display("FAIL redir_pre occ=%0d pc=%h expected 3/000", dut.u_queue.occupancy, instr_pc);
    end
    redirect = 1'b1; redirect_pc = 12'h0A0; instr_ready = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL redir_T req=%b expected 0", mem_req);
    end
    @(negedge CLOCK_50); redirect = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h0A0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL redir_T1 req=%b addr=%h valid=%b expected 1/0a0/0", mem_req, mem_addr, instr_valid);
    end
    @(negedge CLOCK_50); #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 12'h0A1) begin
      failures++; $display("FAIL redir_T2 valid=%b addr=%h expected 0/0a1", instr_valid, mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 12'(12'h0A0 + k) || instr_out !== 16'(32'h10A0 + k)) begin
        failures++; $display("FAIL redir_deliver k=%0d valid=%b pc=%h instr=%h expected 1/%h/%h",
                             k, instr_valid, instr_pc, instr_out, 12'(12'h0A0 + k), 16'(32'h10A0 + k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pc [4];
    exp_pc = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    @(negedge CLOCK_50); redirect = 1'b1; redirect_pc = 12'hFFE; instr_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge CLOCK_50); redirect = 1'b0; #1;
      if (j <= 3) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[j-1]) begin
          failures++; $display("FAIL wrap_issue j=%0d req=%b addr=%h expected 1/%h", j, mem_req, mem_addr, exp_pc[j-1]);
        end
      end
      if (j >= 3) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc[j-3]) begin
          failures++; $display("FAIL wrap_deliver j=%0d valid=%b pc=%h expected 1/%h", j, instr_valid, instr_pc, exp_pc[j-3]);
        end
      end
    end
  endtask

  task automatic test_flush_restart();
    @(negedge CLOCK_50); redirect = 1'b1; redirect_pc = 12'h100; instr_ready = 1'b1;
    @(negedge CLOCK_50); redirect_pc = 12'h200; #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL flush_again req=%b expected 0", mem_req);
    end
    @(negedge CLOCK_50); redirect = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h200) begin
      failures++; $display("FAIL flush_issue req=%b addr=%h expected 1/200", mem_req, mem_addr);
    end
    @(negedge CLOCK_50); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL flush_gap valid=%b pc=%h expected 0", instr_valid, instr_pc);
    end
    @(negedge CLOCK_50); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 12'h200 || instr_out !== 16'h1200) begin
      failures++; $display("FAIL flush_deliver valid=%b pc=%h instr=%h expected 1/200/1200", instr_valid, instr_pc, instr_out);
    end
  endtask

  task automatic test_early_jump();
    logic [11:0] exp_pc [8];
    logic [11:0] got_pc [8];
    logic [15:0] got_in [8];
    int n;
`ifdef FETCH_EARLY_JUMP_EN
    exp_pc = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h040, 12'h041};
`else
    exp_pc = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007};
`endif
    n = 0;
    rom[5] = 16'hF040;
    do_reset(1'b1);
    reset = 1'b0;
    for (int j = 0; j < 30 && n < 8; j++) begin
      @(negedge CLOCK_50); #1;
      if (instr_valid === 1'b1) begin
        got_pc[n] = instr_pc; got_in[n] = instr_out; n++;
      end
    end
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL jump_count got=%0d expected 8", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_pc[k] !== exp_pc[k]) begin
        failures++; $display("FAIL jump_seq k=%0d pc=%h expected %h", k, got_pc[k], exp_pc[k]);
      end
    end
    if (n > 5) begin
      checks++;
      if (got_in[5] !== 16'hF040) begin
        failures++; $display("FAIL jump_instr instr=%h expected f040", got_in[5]);
      end
    end
    rom[5] = 16'h1005;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    reset = 1'b0;
    for (int j = 1; j <= 4; j++) @(negedge CLOCK_50);
    #1;
    checks++;
    if (dut.u_queue.occupancy !== 3'd2) begin
      failures++; $display("FAIL rmid_pre occ=%0d expected 2", dut.u_queue.occupancy);
    end
    reset = 1'b1; redirect = 1'b1; redirect_pc = 12'h300; #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 12'h000 || instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 12'h000) begin
      failures++; $display("FAIL rmid_out req=%b addr=%h valid=%b instr=%h pc=%h expected all 0",
                           mem_req, mem_addr, instr_valid, instr_out, instr_pc);
    end
    @(negedge CLOCK_50); redirect = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 12'h000) begin
      failures++; $display("FAIL rmid_hold valid=%b addr=%h expected 0/000", instr_valid, mem_addr);
    end
    @(negedge CLOCK_50); reset = 1'b0; instr_ready = 1'b1;
    @(negedge CLOCK_50); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
      failures++; $display("FAIL rmid_issue req=%b addr=%h expected 1/000", mem_req, mem_addr);
    end
    @(negedge CLOCK_50); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_stale valid=%b pc=%h expected 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLOCK_50); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 12'(k)) begin
        failures++; $display("FAIL rmid_restart k=%0d valid=%b pc=%h expected 1/%h", k, instr_valid, instr_pc, 12'(k));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'(32'h1000 + i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_flush_restart();
    test_early_jump();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
